// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants.
// Also intended for reuse by the matching transmitter.
package microforth_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 139;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake bundle between the UART receiver and its consumer.
// Defining UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );

endinterface

// File: rtl/uart_sync.sv
// Flop chain bringing an asynchronous serial line into the clk domain.
// Resets to 1 so an idle (high) line never looks like a start bit.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) chain <= '1;
        else        chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on the system clock with a valid/ready byte output.
// Build option UART_RX_PARITY_EN inserts an even-parity bit and parity_err.
module uart_rx
    import microforth_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rxd,
    uart_rx_if.master bus
);

    localparam logic [15:0] HALF     = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] FULL     = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        rxs;
    logic        commit;
    logic        ferr;
`ifdef UART_RX_PARITY_EN
    logic        parity_q, parity_d;
    logic        perr;
`endif

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (rxd),
        .dout (rxs)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 16'd1;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        commit    = 1'b0;
        ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d  = parity_q;
        perr      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                // Mid-start-bit recheck filters glitches shorter than half a bit
                if (bit_cnt_q == HALF) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_cnt_q == FULL) begin
                    bit_cnt_d      = '0;
                    shreg_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_cnt_q == FULL) begin
                    bit_cnt_d = '0;
                    parity_d  = rxs;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving to IDLE right at the sample keeps back-to-back frames lossless
                if (bit_cnt_q == FULL) begin
                    bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    perr = ^shreg_q ^ parity_q;
`endif
                    if (rxs) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                bit_cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            idx_q         <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            idx_q         <= idx_d;
            bus.frame_err <= ferr;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= perr;
`endif
            // A commit that coincides with a transfer is a reload, not an overrun
            if (commit) begin
                bus.rx_data  <= shreg_q;
                bus.rx_valid <= 1'b1;
                bus.overrun  <= bus.rx_valid && !bus.rx_ready;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
                bus.overrun  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        shreg_q  <= shreg_d;
`ifdef UART_RX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a table of single frames
// plus hand-written overrun, glitch, break, reset and parity sequences.
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rxd  (rxd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge
    logic       prev_valid = 1'b0;
    logic [7:0] last_data  = 8'h00;
    int rises = 0, ferrs = 0, perrs = 0, valid_hi = 0, busy_hi = 0;

    always @(negedge clk) begin
        prev_valid <= bus.rx_valid;
        if (bus.rx_valid && !prev_valid) begin
            rises     <= rises + 1;
            last_data <= bus.rx_data;
        end
        if (bus.rx_valid)  valid_hi <= valid_hi + 1;
        if (bus.frame_err) ferrs    <= ferrs + 1;
        if (bus.busy)      busy_hi  <= busy_hi + 1;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err) perrs <= perrs + 1;
`endif
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(CPB);
    endtask

    // Leaves the line at the stop-bit level; callers restore idle themselves
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) rxd = 1'b1;
`endif
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_rises;
        int         exp_ferrs;
    } vec_t;

    vec_t vecs [6];
    int   b_rises, b_ferrs, b_perrs, b_vhi, b_busy;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 0};
        vecs[4] = '{8'h01, 1'b1, 1, 0};
        vecs[5] = '{8'hA5, 1'b0, 0, 1};

        bus.rx_ready = 1'b0;
        tick(3);
        check("reset rx_valid",  32'(bus.rx_valid),  32'h0);
        check("reset rx_data",   32'(bus.rx_data),   32'h0);
        check("reset frame_err", 32'(bus.frame_err), 32'h0);
        check("reset overrun",   32'(bus.overrun),   32'h0);
        check("reset busy",      32'(bus.busy),      32'h0);
        rst_n = 1'b1;
        bus.rx_ready = 1'b1;
        tick(4);

        for (int v = 0; v < 6; v++) begin
            b_rises = rises; b_ferrs = ferrs; b_vhi = valid_hi;
            send_frame(vecs[v].data, vecs[v].stop, ^vecs[v].data);
            rxd = 1'b1;
            tick(8);
            check($sformatf("v%0d rises", v), 32'(rises - b_rises), 32'(vecs[v].exp_rises));
            check($sformatf("v%0d valid width", v), 32'(valid_hi - b_vhi), 32'(vecs[v].exp_rises));
            check($sformatf("v%0d frame_err", v), 32'(ferrs - b_ferrs), 32'(vecs[v].exp_ferrs));
            check($sformatf("v%0d overrun", v), 32'(bus.overrun), 32'h0);
            check($sformatf("v%0d busy", v), 32'(bus.busy), 32'h0);
            if (vecs[v].exp_rises != 0)
                check($sformatf("v%0d rx_data", v), 32'(last_data), 32'(vecs[v].data));
        end

        // Back-to-back frames with no consumer: newest byte wins, overrun set
        bus.rx_ready = 1'b0;
        send_frame(8'hA3, 1'b1, ^8'hA3);
        check("ovr first valid",   32'(bus.rx_valid), 32'h1);
        check("ovr first data",    32'(bus.rx_data),  32'hA3);
        check("ovr first overrun", 32'(bus.overrun),  32'h0);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        rxd = 1'b1;
        tick(2);
        check("ovr second valid",   32'(bus.rx_valid), 32'h1);
        check("ovr second data",    32'(bus.rx_data),  32'h3C);
        check("ovr second overrun", 32'(bus.overrun),  32'h1);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check("ovr clear valid",   32'(bus.rx_valid), 32'h0);
        check("ovr clear overrun", 32'(bus.overrun),  32'h0);
        bus.rx_ready = 1'b1;
        tick(4);

        // Short low glitch on an idle line
        b_rises = rises; b_ferrs = ferrs; b_busy = busy_hi;
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(24);
        check("glitch rises",     32'(rises - b_rises), 32'h0);
        check("glitch frame_err", 32'(ferrs - b_ferrs), 32'h0);
        check("glitch busy seen", 32'((busy_hi - b_busy) inside {[1:15]}), 32'h1);
        check("glitch busy end",  32'(bus.busy), 32'h0);

        // Stop bit low followed by a held break, then recovery
        b_rises = rises; b_ferrs = ferrs;
        send_frame(8'hFF, 1'b0, ^8'hFF);
        rxd = 1'b0;
        tick(40);
        check("break frame_err", 32'(ferrs - b_ferrs), 32'h1);
        check("break rises",     32'(rises - b_rises), 32'h0);
        check("break busy",      32'(bus.busy), 32'h1);
        rxd = 1'b1;
        tick(6);
        check("break busy end", 32'(bus.busy), 32'h0);
        b_rises = rises;
        send_frame(8'h12, 1'b1, ^8'h12);
        rxd = 1'b1;
        tick(8);
        check("after break rises", 32'(rises - b_rises), 32'h1);
        check("after break data",  32'(last_data), 32'h12);

        // Reset in the middle of data bit 4 of 0x81 while a byte is pending
        bus.rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, ^8'h5A);
        rxd = 1'b1;
        tick(4);
        check("pre-reset valid", 32'(bus.rx_valid), 32'h1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        rxd = 1'b0;
        tick(8);
        check("pre-reset busy", 32'(bus.busy), 32'h1);
        b_rises = rises;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        rxd = 1'b1;
        check("mid reset rx_valid",  32'(bus.rx_valid),  32'h0);
        check("mid reset rx_data",   32'(bus.rx_data),   32'h0);
        check("mid reset frame_err", 32'(bus.frame_err), 32'h0);
        check("mid reset overrun",   32'(bus.overrun),   32'h0);
        check("mid reset busy",      32'(bus.busy),      32'h0);
        tick(200);
        check("abandoned frame rises", 32'(rises - b_rises), 32'h0);
        send_frame(8'h81, 1'b1, ^8'h81);
        rxd = 1'b1;
        tick(4);
        check("post reset valid",   32'(bus.rx_valid), 32'h1);
        check("post reset data",    32'(bus.rx_data),  32'h81);
        check("post reset overrun", 32'(bus.overrun),  32'h0);
        bus.rx_ready = 1'b1;
        tick(4);

`ifdef UART_RX_PARITY_EN
        b_rises = rises; b_perrs = perrs;
        send_frame(8'h07, 1'b1, 1'b1);
        rxd = 1'b1;
        tick(8);
        check("parity ok rises", 32'(rises - b_rises), 32'h1);
        check("parity ok err",   32'(perrs - b_perrs), 32'h0);
        check("parity ok data",  32'(last_data), 32'h07);
        b_rises = rises; b_perrs = perrs;
        send_frame(8'h07, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(8);
        check("parity bad rises", 32'(rises - b_rises), 32'h1);
        check("parity bad err",   32'(perrs - b_perrs), 32'h1);
        check("parity bad data",  32'(last_data), 32'h07);
`else
        b_perrs = perrs;
        check("parity counter idle", 32'(perrs - b_perrs), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
